// File: rtl/ucsbece154a_mc_controller_if.sv
// Control-unit <-> datapath bundle: IR fields and flags in, mux selects and enables out.
// The controller connects through 'slave'; the datapath (or a bench) uses 'master'.
interface ucsbece154a_mc_controller_if;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i;
    logic       zero_i;
    logic       MemReady_i;
    logic       PCWrite_o;
    logic       AdrSrc_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic [1:0] ResultSrc_o;
    logic [1:0] ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic       RegWrite_o;
    logic [2:0] ALUControl_o;
    logic [2:0] ImmSrc_o;
    logic       Retire_o;
    logic       Illegal_o;

    modport slave (
        input  op_i, funct3_i, funct7b5_i, zero_i, MemReady_i,
        output PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o, ALUSrcA_o,
               ALUSrcB_o, RegWrite_o, ALUControl_o, ImmSrc_o, Retire_o, Illegal_o
    );

    modport master (
        output op_i, funct3_i, funct7b5_i, zero_i, MemReady_i,
        input  PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, ResultSrc_o, ALUSrcA_o,
               ALUSrcB_o, RegWrite_o, ALUControl_o, ImmSrc_o, Retire_o, Illegal_o
    );
endinterface

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM with memory-ready stalls, optional bne,
// retire pulse and illegal-op flag, plus combinational ALU and immediate decoders.
module ucsbece154a_mc_controller #(
    parameter bit MEM_WAIT   = 1'b1,
    parameter bit BRANCH_EXT = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    ucsbece154a_mc_controller_if.slave  ctl
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BRANCH, S_LUI
    } state_e;

    state_e     state_q, state_d;
    logic       rdy, taken;
    logic [1:0] alu_op;
    logic       pc_write, mem_write, ir_write, reg_write, retire, illegal;

    assign rdy   = ctl.MemReady_i | ~MEM_WAIT;
    assign taken = ((ctl.funct3_i == 3'b000) & ctl.zero_i)
                 | (BRANCH_EXT & (ctl.funct3_i == 3'b001) & ~ctl.zero_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (ctl.op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (rdy) state_d = S_MEMWB;
            S_MEMWRITE: if (rdy) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_LUI: state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctl.AdrSrc_o    = 1'b0;
        ctl.ResultSrc_o = 2'b00;
        ctl.ALUSrcA_o   = 2'b00;
        ctl.ALUSrcB_o   = 2'b00;
        alu_op          = 2'b00;
        pc_write        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_write       = 1'b0;
        retire          = 1'b0;
        illegal         = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctl.ALUSrcB_o   = 2'b10;
                ctl.ResultSrc_o = 2'b10;
                ir_write        = rdy;
                pc_write        = rdy;
            end
            S_DECODE: begin
                ctl.ALUSrcA_o = 2'b01;
                ctl.ALUSrcB_o = 2'b01;
                case (ctl.op_i)
                    OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_LUI: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ctl.ALUSrcA_o = 2'b10;
                ctl.ALUSrcB_o = 2'b01;
            end
            S_MEMREAD:  ctl.AdrSrc_o = 1'b1;
            S_MEMWB: begin
                ctl.ResultSrc_o = 2'b01;
                reg_write       = 1'b1;
                retire          = 1'b1;
            end
            S_MEMWRITE: begin
                ctl.AdrSrc_o = 1'b1;
                mem_write    = 1'b1;
                retire       = rdy;
            end
            S_EXECR: begin
                ctl.ALUSrcA_o = 2'b10;
                alu_op        = 2'b10;
            end
            S_EXECI: begin
                ctl.ALUSrcA_o = 2'b10;
                ctl.ALUSrcB_o = 2'b01;
                alu_op        = 2'b10;
            end
            S_JAL: begin
                ctl.ALUSrcA_o = 2'b01;
                ctl.ALUSrcB_o = 2'b10;
                pc_write      = 1'b1;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                ctl.ALUSrcA_o = 2'b10;
                alu_op        = 2'b01;
                pc_write      = taken;
                retire        = 1'b1;
            end
            S_LUI: begin
                ctl.ResultSrc_o = 2'b11;
                reg_write       = 1'b1;
                retire          = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are held low for as long as reset is asserted.
    assign ctl.PCWrite_o  = pc_write  & ~reset;
    assign ctl.MemWrite_o = mem_write & ~reset;
    assign ctl.IRWrite_o  = ir_write  & ~reset;
    assign ctl.RegWrite_o = reg_write & ~reset;
    assign ctl.Retire_o   = retire    & ~reset;
    assign ctl.Illegal_o  = illegal   & ~reset;

    always_comb begin
        ctl.ALUControl_o = ALU_ADD;
        case (alu_op)
            2'b01: ctl.ALUControl_o = ALU_SUB;
            2'b10: begin
                case (ctl.funct3_i)
                    3'b000:  ctl.ALUControl_o = (ctl.funct7b5_i & ctl.op_i[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  ctl.ALUControl_o = ALU_SLT;
                    3'b110:  ctl.ALUControl_o = ALU_OR;
                    3'b111:  ctl.ALUControl_o = ALU_AND;
                    default: ctl.ALUControl_o = ALU_ADD;
                endcase
            end
            default: ctl.ALUControl_o = ALU_ADD;
        endcase
    end

    always_comb begin
        case (ctl.op_i)
            OP_SW:   ctl.ImmSrc_o = 3'b001;
            OP_B:    ctl.ImmSrc_o = 3'b010;
            OP_JAL:  ctl.ImmSrc_o = 3'b011;
            OP_LUI:  ctl.ImmSrc_o = 3'b100;
            default: ctl.ImmSrc_o = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Bench for the multicycle controller: an instruction-level model expands each
// instruction into its expected per-cycle control vector; two parameterisations.
module tb_ucsbece154a_mc_controller;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rw;
        logic [2:0] alu;
        logic [2:0] imm;
        logic       ret;
        logic       ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    ucsbece154a_mc_controller_if ifa ();
    ucsbece154a_mc_controller_if ifb ();

    ucsbece154a_mc_controller #(.MEM_WAIT(1'b1), .BRANCH_EXT(1'b1)) dut_a (
        .clk(clk), .reset(rst_a), .ctl(ifa));
    ucsbece154a_mc_controller #(.MEM_WAIT(1'b0), .BRANCH_EXT(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .ctl(ifb));

    vec_t  exp_q[$];
    string tag_q[$];
    bit    sel_q[$];
    vec_t  log_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    steps_left = -1;
    logic [6:0] cur_op [2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    function automatic vec_t get_out(input bit sel);
        vec_t o;
        if (sel) o = {ifb.PCWrite_o, ifb.AdrSrc_o, ifb.MemWrite_o, ifb.IRWrite_o, ifb.ResultSrc_o,
                      ifb.ALUSrcA_o, ifb.ALUSrcB_o, ifb.RegWrite_o, ifb.ALUControl_o,
                      ifb.ImmSrc_o, ifb.Retire_o, ifb.Illegal_o};
        else     o = {ifa.PCWrite_o, ifa.AdrSrc_o, ifa.MemWrite_o, ifa.IRWrite_o, ifa.ResultSrc_o,
                      ifa.ALUSrcA_o, ifa.ALUSrcB_o, ifa.RegWrite_o, ifa.ALUControl_o,
                      ifa.ImmSrc_o, ifa.Retire_o, ifa.Illegal_o};
        return o;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == SW)  return 3'b001;
        if (op == BR)  return 3'b010;
        if (op == JAL) return 3'b011;
        if (op == LUI) return 3'b100;
        return 3'b000;
    endfunction

    function automatic bit known(input logic [6:0] op);
        return op == LW || op == SW || op == RT || op == IT || op == BR || op == JAL || op == LUI;
    endfunction

    // R-type f3=000 is add/sub by IR[30]; immediates never subtract.
    function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (op == RT && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic int count(input int field);
        int n = 0;
        foreach (log_q[i]) begin
            if (field == 0 && log_q[i].ret)  n++;
            if (field == 1 && log_q[i].memw) n++;
            if (field == 2 && log_q[i].rw)   n++;
        end
        return n;
    endfunction

    always @(negedge clk) begin
        vec_t e, g;
        string t;
        bit s;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            g = get_out(s);
            log_q.push_back(g);
            chk(t, 32'(g), 32'(e));
        end
    end

    task automatic step(input bit sel, input vec_t e, input bit rdy, input string tag);
        if (steps_left == 0) return;
        if (steps_left > 0) steps_left--;
        if (sel) ifb.MemReady_i = rdy; else ifa.MemReady_i = rdy;
        exp_q.push_back(e); tag_q.push_back(tag); sel_q.push_back(sel);
        @(posedge clk); #1;
    endtask

    // kind: 0 fetch, 1 memread, 2 memwrite; MemReady low for 'stalls' cycles
    task automatic mem_phase(input bit sel, input vec_t e0, input int stalls, input int kind, input string tag);
        bit r, eff;
        vec_t e;
        for (int i = 0; i < 64; i++) begin
            r   = (i >= stalls);
            eff = r | sel;
            e   = e0;
            if (kind == 0) begin e.irw = eff; e.pcw = eff; end
            if (kind == 2) e.ret = eff;
            step(sel, e, r, tag);
            if (eff || steps_left == 0) break;
        end
    endtask

    task automatic run_instr(input bit sel, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int sf, input int sm, input int stop);
        vec_t b, e;
        if (sel) begin ifb.op_i = op; ifb.funct3_i = f3; ifb.funct7b5_i = f7; ifb.zero_i = z; end
        else     begin ifa.op_i = op; ifa.funct3_i = f3; ifa.funct7b5_i = f7; ifa.zero_i = z; end
        cur_op[sel] = op;
        log_q.delete();
        steps_left = stop;
        b = '0; b.imm = imm_of(op);
        e = b; e.sb = 2'b10; e.res = 2'b10;
        mem_phase(sel, e, sf, 0, "fetch");
        e = b; e.sa = 2'b01; e.sb = 2'b01; e.ill = !known(op);
        step(sel, e, 1'b0, "decode");
        if (op == LW || op == SW) begin
            e = b; e.sa = 2'b10; e.sb = 2'b01;
            step(sel, e, 1'b0, "memadr");
            if (op == LW) begin
                e = b; e.adr = 1'b1;
                mem_phase(sel, e, sm, 1, "memread");
                e = b; e.res = 2'b01; e.rw = 1'b1; e.ret = 1'b1;
                step(sel, e, 1'b0, "memwb");
            end else begin
                e = b; e.adr = 1'b1; e.memw = 1'b1;
                mem_phase(sel, e, sm, 2, "memwrite");
            end
        end else if (op == RT || op == IT || op == JAL) begin
            e = b;
            if (op == JAL) begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            else begin e.sa = 2'b10; e.sb = (op == IT) ? 2'b01 : 2'b00; e.alu = alu_of(op, f3, f7); end
            step(sel, e, 1'b0, "exec");
            e = b; e.rw = 1'b1; e.ret = 1'b1;
            step(sel, e, 1'b0, "aluwb");
        end else if (op == BR) begin
            e = b; e.sa = 2'b10; e.alu = 3'b001; e.ret = 1'b1;
            e.pcw = (f3 == 3'b000 && z) || (!sel && f3 == 3'b001 && !z);
            step(sel, e, 1'b0, "branch");
        end else if (op == LUI) begin
            e = b; e.res = 2'b11; e.rw = 1'b1; e.ret = 1'b1;
            step(sel, e, 1'b0, "lui");
        end
        steps_left = -1;
    endtask

    // Reset with MemReady high: an ungated fetch would show IRWrite/PCWrite here.
    task automatic do_reset(input bit sel, input int n);
        vec_t e;
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        e = '0; e.sb = 2'b10; e.res = 2'b10; e.imm = imm_of(cur_op[sel]);
        for (int i = 0; i < n; i++) step(sel, e, 1'b1, "reset");
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.op_i = LW; ifa.funct3_i = 3'b010; ifa.funct7b5_i = 1'b0; ifa.zero_i = 1'b0; ifa.MemReady_i = 1'b1;
        ifb.op_i = LW; ifb.funct3_i = 3'b010; ifb.funct7b5_i = 1'b0; ifb.zero_i = 1'b0; ifb.MemReady_i = 1'b1;
        cur_op[0] = LW; cur_op[1] = LW;
        @(posedge clk); #1;
        do_reset(1'b0, 2);

        run_instr(1'b0, LW, 3'b010, 1'b0, 1'b0, 0, 0, -1);
        chk("lw_len", 32'(log_q.size()), 32'd5);
        chk("lw_wb_c5", 32'({log_q[4].rw, log_q[4].res}), 32'b101);
        chk("lw_rw_c4", 32'(log_q[3].rw), 32'd0);
        chk("lw_retire", 32'(count(0)), 32'd1);

        run_instr(1'b0, SW, 3'b010, 1'b0, 1'b0, 1, 3, -1);
        chk("sw_memw_cyc", 32'(count(1)), 32'd4);
        chk("sw_len", 32'(log_q.size()), 32'd8);
        chk("sw_ret_last", 32'(log_q[7].ret), 32'd1);
        chk("sw_retire", 32'(count(0)), 32'd1);

        run_instr(1'b0, LW, 3'b010, 1'b0, 1'b0, 2, 2, -1);
        run_instr(1'b0, BR, 3'b001, 1'b0, 1'b0, 0, 0, -1);
        chk("bne_ext_pcw", 32'(log_q[2].pcw), 32'd1);
        run_instr(1'b0, BR, 3'b001, 1'b0, 1'b1, 0, 0, -1);
        run_instr(1'b0, BR, 3'b000, 1'b0, 1'b1, 0, 0, -1);
        run_instr(1'b0, BR, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(1'b0, BR, 3'b100, 1'b0, 1'b1, 0, 0, -1);
        chk("blt_len", 32'(log_q.size()), 32'd3);

        run_instr(1'b0, RT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        chk("sub_alu", 32'(log_q[2].alu), 32'b001);
        run_instr(1'b0, RT, 3'b111, 1'b0, 1'b0, 0, 0, -1);
        run_instr(1'b0, RT, 3'b010, 1'b0, 1'b0, 0, 0, -1);
        run_instr(1'b0, RT, 3'b110, 1'b0, 1'b0, 0, 0, -1);
        run_instr(1'b0, IT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        chk("addi_ir30_alu", 32'(log_q[2].alu), 32'b000);
        run_instr(1'b0, IT, 3'b111, 1'b0, 1'b0, 0, 0, -1);
        run_instr(1'b0, JAL, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        chk("jal_len", 32'(log_q.size()), 32'd4);
        run_instr(1'b0, LUI, 3'b000, 1'b0, 1'b0, 0, 0, -1);

        run_instr(1'b0, BAD, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        chk("ill_len", 32'(log_q.size()), 32'd2);
        chk("ill_pulse", 32'(log_q[1].ill), 32'd1);
        chk("ill_no_wr", 32'(count(1) + count(2)), 32'd0);
        run_instr(1'b0, LUI, 3'b000, 1'b0, 1'b0, 0, 0, -1);

        run_instr(1'b0, SW, 3'b000, 1'b0, 1'b0, 0, 6, 5);
        do_reset(1'b0, 1);
        run_instr(1'b0, LW, 3'b000, 1'b0, 1'b0, 0, 1, -1);

        do_reset(1'b1, 1);
        run_instr(1'b1, LW, 3'b010, 1'b0, 1'b0, 3, 3, -1);
        chk("nowait_lw_len", 32'(log_q.size()), 32'd5);
        run_instr(1'b1, LW, 3'b010, 1'b0, 1'b0, 0, 0, 4);
        do_reset(1'b1, 2);
        run_instr(1'b1, SW, 3'b010, 1'b0, 1'b0, 2, 2, -1);
        chk("rel_fetch_en", 32'({log_q[0].irw, log_q[0].pcw}), 32'b11);
        chk("nowait_sw_memw", 32'(count(1)), 32'd1);
        run_instr(1'b1, BR, 3'b001, 1'b0, 1'b0, 0, 0, -1);
        chk("bne_noext_pcw", 32'(log_q[2].pcw), 32'd0);
        run_instr(1'b1, BR, 3'b000, 1'b0, 1'b1, 0, 0, -1);
        chk("beq_noext_pcw", 32'(log_q[2].pcw), 32'd1);
        run_instr(1'b1, RT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
        run_instr(1'b1, BAD, 3'b000, 1'b0, 1'b0, 0, 0, -1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
